// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arbiter
// Purpose  : Detects rising/falling edges on N synchronous inputs, holds one
//            pending event per channel and serialises the events onto a
//            single valid/ready port using round-robin arbitration. A sticky
//            per-channel overflow flag records an edge lost because the
//            channel already held an unserviced event.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            a_i               - monitored inputs (synchronous to clk)
//            rise_en_i         - per-channel rising-edge enable
//            fall_en_i         - per-channel falling-edge enable
//            evt_valid_o       - event presented
//            evt_ready_i       - consumer accepts the presented event
//            evt_id_o          - channel number of the presented event
//            evt_rise_o        - 1 = rising edge, 0 = falling edge
//            ovf_o             - sticky per-channel overflow flags
//            ovf_clr_i         - per-channel overflow clear pulse
// Revision : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    a_i,
    input  logic [N-1:0]    rise_en_i,
    input  logic [N-1:0]    fall_en_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [ID_W-1:0] evt_id_o,
    output logic            evt_rise_o,
    output logic [N-1:0]    ovf_o,
    input  logic [N-1:0]    ovf_clr_i
);

    localparam logic [0:0]      S_IDLE    = 1'b0;
    localparam logic [0:0]      S_PRESENT = 1'b1;
    localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(N - 1);
    localparam logic [N-1:0]    C_ONE     = N'(1);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [N-1:0]    r_a_ff;
    logic [N-1:0]    r_pending;
    logic [N-1:0]    r_pend_rise;
    logic [N-1:0]    r_ovf;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_evt_id;
    logic            r_evt_rise;

    logic [N-1:0]    w_rise;
    logic [N-1:0]    w_fall;
    logic [N-1:0]    w_edge;
    logic            w_found;
    logic [ID_W-1:0] w_sel;
    logic [ID_W-1:0] w_idx;
    int              w_pos;
    logic            w_load;
    logic [N-1:0]    w_load_mask;
    logic [N-1:0]    w_take;
    logic [N-1:0]    w_ovf_set;
    logic [ID_W-1:0] w_ptr_nxt;

    // Edge detection against last cycle's sample.
    assign w_rise = ~r_a_ff &  a_i & rise_en_i;
    assign w_fall =  r_a_ff & ~a_i & fall_en_i;
    assign w_edge = w_rise | w_fall;

    // Round-robin search: first pending channel at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(r_rr_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = w_pos[ID_W-1:0];
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // FSM next state and load decision. The pending set used here is the one
    // registered before this cycle's edges, so a new edge costs one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (evt_ready_i) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_load_mask = w_load ? (C_ONE << w_sel) : '0;
    // A new edge becomes the pending event when the slot is free or is being
    // vacated by this cycle's load; otherwise the oldest event is kept.
    assign w_take      = w_edge & (~r_pending | w_load_mask);
    assign w_ovf_set   = w_edge & r_pending & ~w_load_mask;
    assign w_ptr_nxt   = (w_sel == C_LAST_ID) ? '0 : w_sel + ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_ff      <= '0;
            r_pending   <= '0;
            r_pend_rise <= '0;
            r_ovf       <= '0;
            r_rr_ptr    <= '0;
            r_evt_id    <= '0;
            r_evt_rise  <= 1'b0;
        end else begin
            r_a_ff      <= a_i;
            r_pending   <= (r_pending & ~w_load_mask) | w_edge;
            r_pend_rise <= (r_pend_rise & ~w_take) | (w_rise & w_take);
            r_ovf       <= (r_ovf & ~ovf_clr_i) | w_ovf_set;
            if (w_load) begin
                r_evt_id   <= w_sel;
                r_evt_rise <= r_pend_rise[w_sel];
                r_rr_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign evt_valid_o = (r_state == S_PRESENT);
    assign evt_id_o    = r_evt_id;
    assign evt_rise_o  = r_evt_rise;
    assign ovf_o       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_arbiter
// Purpose  : Self-checking bench for edge_event_arbiter (N = 4): directed
//            vector table, hand-written corner sequences and a randomized
//            run compared against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a;
    logic [3:0] ren;
    logic [3:0] fen;
    logic       rdy;
    logic [3:0] clr;
    logic       valid;
    logic [1:0] id;
    logic       rise;
    logic [3:0] ovf;

    int tests = 0;
    int fails = 0;

    edge_event_arbiter #(.N(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_i         (a),
        .rise_en_i   (ren),
        .fall_en_i   (fen),
        .evt_valid_o (valid),
        .evt_ready_i (rdy),
        .evt_id_o    (id),
        .evt_rise_o  (rise),
        .ovf_o       (ovf),
        .ovf_clr_i   (clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] ren;
        logic [3:0] fen;
        logic       rdy;
        logic [3:0] clr;
        logic       ev;
        logic [1:0] eid;
        logic       erise;
        logic [3:0] eovf;
    } vec_t;

    vec_t tbl[19];

    // Reference model state (per-channel arrays, plain integers).
    int m_hist[4];
    int m_pend[4];
    int m_prise[4];
    int m_ovf[4];
    int m_ptr;
    int m_valid;
    int m_id;
    int m_rise;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int  sel;
        bit  hs;
        bit  load;
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                m_hist[c] = 0; m_pend[c] = 0; m_prise[c] = 0; m_ovf[c] = 0;
            end
            m_ptr = 0; m_valid = 0; m_id = 0; m_rise = 0;
            return;
        end
        sel = -1;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (sel < 0 && m_pend[c] != 0) sel = c;
        end
        hs   = (m_valid != 0) && rdy;
        load = (sel >= 0) && ((m_valid == 0) || hs);
        if (load) begin
            m_id   = sel;
            m_rise = m_prise[sel];
        end
        for (int c = 0; c < 4; c++) begin
            bit r;
            bit f;
            bit lt;
            r  = (m_hist[c] == 0) && a[c] && ren[c];
            f  = (m_hist[c] != 0) && !a[c] && fen[c];
            lt = load && (sel == c);
            if (clr[c]) m_ovf[c] = 0;
            if (r || f) begin
                if (m_pend[c] == 0 || lt) begin
                    m_pend[c]  = 1;
                    m_prise[c] = r ? 1 : 0;
                end else begin
                    m_ovf[c] = 1;
                end
            end else if (lt) begin
                m_pend[c] = 0;
            end
            m_hist[c] = a[c] ? 1 : 0;
        end
        if (load) begin
            m_valid = 1;
            m_ptr   = (sel + 1) % 4;
        end else if (hs) begin
            m_valid = 0;
        end
    endtask

    function automatic int model_ovf();
        int v;
        v = 0;
        for (int c = 0; c < 4; c++) v = v | (m_ovf[c] << c);
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int prev;
        int n0;
        int n3;

        //               a        ren    fen    rdy   clr    ev    id    rise  ovf
        tbl[0]  = '{4'b1011, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b1011, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1, 4'b0000};
        tbl[2]  = '{4'b1011, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[3]  = '{4'b1011, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 1'b1, 4'b0000};
        tbl[4]  = '{4'b1011, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[5]  = '{4'b1011, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[6]  = '{4'b1111, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[7]  = '{4'b1111, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[8]  = '{4'b1011, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[9]  = '{4'b1111, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 4'b0100};
        tbl[10] = '{4'b1111, 4'hF, 4'hF, 1'b0, 4'h4, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[11] = '{4'b1111, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 1'b0, 4'b0000};
        tbl[12] = '{4'b1111, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[13] = '{4'b1101, 4'hF, 4'hD, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[14] = '{4'b1111, 4'hD, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[15] = '{4'b1101, 4'hD, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[16] = '{4'b1101, 4'hD, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 1'b0, 4'b0000};
        tbl[17] = '{4'b1101, 4'hD, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[18] = '{4'b1101, 4'hD, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000};

        // Channel 0 held high through reset release.
        reset = 1'b1; a = 4'b0001; ren = 4'hF; fen = 4'hF; rdy = 1'b0; clr = 4'h0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_release_valid_c1", int'(valid), 0);
        tick();
        chk("rst_release_valid_c2", int'(valid), 1);
        chk("rst_release_id", int'(id), 0);
        chk("rst_release_rise", int'(rise), 1);
        rdy = 1'b1;
        tick();
        chk("rst_release_drop", int'(valid), 0);

        // Reset state.
        reset = 1'b1; a = 4'b0000; rdy = 1'b0;
        tick();
        chk("reset_valid", int'(valid), 0);
        chk("reset_id", int'(id), 0);
        chk("reset_rise", int'(rise), 0);
        chk("reset_ovf", int'(ovf), 0);
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 19; i++) begin
            a = tbl[i].a; ren = tbl[i].ren; fen = tbl[i].fen;
            rdy = tbl[i].rdy; clr = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].eovf));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_id", i), int'(id), int'(tbl[i].eid));
                chk($sformatf("tbl%0d_rise", i), int'(rise), int'(tbl[i].erise));
            end
        end
        clr = 4'h0;

        // Fairness: channels 0 and 3 edge every cycle, consumer always ready.
        reset = 1'b1; a = 4'b0000; ren = 4'hF; fen = 4'hF; rdy = 1'b1;
        tick();
        reset = 1'b0;
        prev = -1; n0 = 0; n3 = 0;
        for (int c = 0; c < 16; c++) begin
            a = (c % 2 == 0) ? 4'b1001 : 4'b0000;
            tick();
            if (c >= 1) chk($sformatf("fair%0d_valid", c), int'(valid), 1);
            if (valid) begin
                chk($sformatf("fair%0d_id_legal", c), int'(id == 2'd0 || id == 2'd3), 1);
                if (prev >= 0) chk($sformatf("fair%0d_alternate", c), int'(int'(id) != prev), 1);
                prev = int'(id);
                if (id == 2'd0) n0++;
                if (id == 2'd3) n3++;
            end
        end
        chk("fair_ch0_count", int'(n0 >= 6), 1);
        chk("fair_ch3_count", int'(n3 >= 6), 1);

        // Reset while an event is presented and another is pending.
        reset = 1'b1; a = 4'b0000; rdy = 1'b0;
        tick();
        reset = 1'b0;
        a = 4'b0110;
        tick();
        tick();
        chk("midrst_pre_valid", int'(valid), 1);
        reset = 1'b1; a = 4'b0000;
        tick();
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_ovf", int'(ovf), 0);
        reset = 1'b0; rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("midrst_quiet%0d", c), int'(valid), 0);
        end

        // Randomized run against the reference model.
        reset = 1'b1; a = 4'b0000; clr = 4'h0;
        model_step();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 2) == 0) a[b] = ~a[b];
            end
            ren = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            fen = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            model_step();
            tick();
            chk($sformatf("rnd%0d_valid", c), int'(valid), m_valid);
            chk($sformatf("rnd%0d_ovf", c), int'(ovf), model_ovf());
            if (m_valid != 0) begin
                chk($sformatf("rnd%0d_id", c), int'(id), m_id);
                chk($sformatf("rnd%0d_rise", c), int'(rise), m_rise);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
